// File: rtl/comparator_bist_if.sv
`default_nettype none
// ============================================================================
// Module   : comparator_bist_if
// Purpose  : Bundles the comparator operand/result bus and BIST status lines.
// Revision : 1.0 - initial release
// ============================================================================
interface comparator_bist_if #(
    parameter int WIDTH = 2
);
    logic                 start;
    logic [WIDTH-1:0]     dut_a;
    logic [WIDTH-1:0]     dut_b;
    logic [2:0]           dut_f;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [2*WIDTH:0]     err_count;
    logic [2*WIDTH-1:0]   first_fail_vec;
    logic                 first_fail_valid;

    // master is the BIST engine; slave is the comparator/controller side
    modport master (
        input  start, dut_f,
        output dut_a, dut_b, busy, done, pass,
               err_count, first_fail_vec, first_fail_valid
    );

    modport slave (
        output start, dut_f,
        input  dut_a, dut_b, busy, done, pass,
               err_count, first_fail_vec, first_fail_valid
    );
endinterface
`default_nettype wire

// File: rtl/comparator_bist.sv
`default_nettype none
// ============================================================================
// Module   : comparator_bist
// Purpose  : Exhaustive hardware sweep of a 3-output comparator, counting and
//            capturing mismatches against an internal expectation.
// Revision : 1.0 - initial release
// ============================================================================
module comparator_bist #(
    parameter int WIDTH  = 2,
    parameter int SETTLE = 1
) (
    input  wire logic          clk,
    input  wire logic          rst,
    comparator_bist_if.master  cmp_if
);
    localparam int VW = 2 * WIDTH;
    localparam int EW = 2 * WIDTH + 1;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] C_SETTLE_LAST = CW'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [VW-1:0]   vec_q, vec_d;
    logic [CW-1:0]   settle_q, settle_d;
    logic [EW-1:0]   err_q, err_d;
    logic [VW-1:0]   ffvec_q, ffvec_d;
    logic            ffvalid_q, ffvalid_d;

    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [2:0]       w_expect;
    logic             w_mismatch;

    assign w_a        = vec_q[VW-1:WIDTH];
    assign w_b        = vec_q[WIDTH-1:0];
    assign w_expect   = {w_a > w_b, w_a == w_b, w_a < w_b};
    // Full 3-bit compare so non-one-hot results are also flagged
    assign w_mismatch = (cmp_if.dut_f != w_expect);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            vec_q     <= '0;
            settle_q  <= '0;
            err_q     <= '0;
            ffvec_q   <= '0;
            ffvalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            vec_q     <= vec_d;
            settle_q  <= settle_d;
            err_q     <= err_d;
            ffvec_q   <= ffvec_d;
            ffvalid_q <= ffvalid_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        settle_d  = settle_q;
        err_d     = err_q;
        ffvec_d   = ffvec_q;
        ffvalid_d = ffvalid_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (cmp_if.start) begin
                    state_d   = S_DRIVE;
                    vec_d     = '0;
                    settle_d  = '0;
                    err_d     = '0;
                    ffvalid_d = 1'b0;
                end
            end
            S_DRIVE: begin
                if (settle_q == C_SETTLE_LAST) begin
                    state_d = S_CHECK;
                end else begin
                    settle_d = settle_q + CW'(1);
                end
            end
            S_CHECK: begin
                if (w_mismatch) begin
                    err_d = err_q + EW'(1);
                    if (!ffvalid_q) begin
                        ffvec_d   = vec_q;
                        ffvalid_d = 1'b1;
                    end
                end
                // Last vector stays on the operand bus after the sweep
                if (vec_q != {VW{1'b1}}) begin
                    vec_d    = vec_q + VW'(1);
                    settle_d = '0;
                    state_d  = S_DRIVE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign cmp_if.dut_a            = w_a;
    assign cmp_if.dut_b            = w_b;
    assign cmp_if.busy             = (state_q == S_DRIVE) || (state_q == S_CHECK);
    assign cmp_if.done             = (state_q == S_DONE);
    assign cmp_if.pass             = (state_q == S_DONE) && (err_q == '0);
    assign cmp_if.err_count        = err_q;
    assign cmp_if.first_fail_vec   = ffvec_q;
    assign cmp_if.first_fail_valid = ffvalid_q;
endmodule
`default_nettype wire

// File: tb/tb_comparator_bist.sv
`default_nettype none
// ============================================================================
// Module   : tb_comparator_bist
// Purpose  : Self-checking bench driving ideal and faulty comparator models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_comparator_bist;
    localparam int W    = 2;
    localparam int NVEC = 1 << (2 * W);

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    int         fault_mode = 0;
    logic [2:0] fault_mask [NVEC];

    comparator_bist_if #(.WIDTH(W)) bus ();

    comparator_bist #(.WIDTH(W), .SETTLE(1)) dut (
        .clk    (clk),
        .rst    (rst),
        .cmp_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] ideal_f(int a, int b);
        return {a > b, a == b, a < b};
    endfunction

    // Comparator under test: ideal, stuck-010, stuck-000, gt/lt swapped, random faults
    function automatic logic [2:0] model_f(int mode, int a, int b);
        logic [2:0] f;
        f = ideal_f(a, b);
        case (mode)
            1:       return 3'b010;
            2:       return 3'b000;
            3:       return {f[0], f[1], f[2]};
            4:       return f ^ fault_mask[a * (1 << W) + b];
            default: return f;
        endcase
    endfunction

    always_comb bus.dut_f = model_f(fault_mode, int'(bus.dut_a), int'(bus.dut_b));

    // Pulses start (sampled at "cycle 0") and watches until done, optionally re-pulsing mid-sweep
    task automatic run_sweep(input int repulse_vec, output int busy_n, output int done_n);
        bit pulsed = 1'b0;
        busy_n = 0;
        done_n = 0;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int n = 1; n <= 200 && done_n == 0; n++) begin
            if (bus.busy) busy_n++;
            if (bus.done) done_n = n;
            if (repulse_vec >= 0 && !pulsed && bus.busy &&
                int'({bus.dut_a, bus.dut_b}) == repulse_vec) begin
                bus.start = 1'b1;
                pulsed    = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            if (done_n == 0) @(negedge clk);
        end
        bus.start = 1'b0;
    endtask

    task automatic test_sweep(input int mode, input string name, input int repulse_vec);
        int busy_n, done_n, exp_err, exp_first;
        exp_err   = 0;
        exp_first = -1;
        for (int v = 0; v < NVEC; v++) begin
            if (model_f(mode, v >> W, v % (1 << W)) !== ideal_f(v >> W, v % (1 << W))) begin
                exp_err++;
                if (exp_first < 0) exp_first = v;
            end
        end
        fault_mode = mode;
        run_sweep(repulse_vec, busy_n, done_n);

        checks++;
        if (done_n !== NVEC * 2 + 1) begin
            failures++;
            $display("FAIL %s done_cycle: got %0d want %0d", name, done_n, NVEC * 2 + 1);
        end
        checks++;
        if (busy_n !== NVEC * 2) begin
            failures++;
            $display("FAIL %s busy_cycles: got %0d want %0d", name, busy_n, NVEC * 2);
        end
        checks++;
        if (int'(bus.err_count) !== exp_err) begin
            failures++;
            $display("FAIL %s err_count: got %0d want %0d", name, bus.err_count, exp_err);
        end
        checks++;
        if (bus.pass !== (exp_err == 0)) begin
            failures++;
            $display("FAIL %s pass: got %0b want %0b", name, bus.pass, exp_err == 0);
        end
        checks++;
        if (bus.first_fail_valid !== (exp_first >= 0)) begin
            failures++;
            $display("FAIL %s first_fail_valid: got %0b want %0b", name, bus.first_fail_valid, exp_first >= 0);
        end
        if (exp_first >= 0) begin
            checks++;
            if (int'(bus.first_fail_vec) !== exp_first) begin
                failures++;
                $display("FAIL %s first_fail_vec: got %0d want %0d", name, bus.first_fail_vec, exp_first);
            end
        end
        checks++;
        if ({bus.dut_a, bus.dut_b} !== 4'b1111) begin
            failures++;
            $display("FAIL %s last_vec: got %0h want f", name, {bus.dut_a, bus.dut_b});
        end
        // Results must hold while idle in DONE
        repeat (3) @(negedge clk);
        checks++;
        if (bus.done !== 1'b1 || int'(bus.err_count) !== exp_err) begin
            failures++;
            $display("FAIL %s done_hold: got done=%0b err=%0d want done=1 err=%0d",
                     name, bus.done, bus.err_count, exp_err);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bus.start = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.pass !== 1'b0 ||
            bus.err_count !== '0 || bus.first_fail_vec !== '0 ||
            bus.first_fail_valid !== 1'b0 || bus.dut_a !== '0 || bus.dut_b !== '0) begin
            failures++;
            $display("FAIL reset_state: got busy=%0b done=%0b pass=%0b err=%0d ffv=%0h ffvalid=%0b a=%0d b=%0d want all zero",
                     bus.busy, bus.done, bus.pass, bus.err_count, bus.first_fail_vec,
                     bus.first_fail_valid, bus.dut_a, bus.dut_b);
        end
        rst       = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_beats_start: got busy=%0b want 0", bus.busy);
        end
    endtask

    task automatic test_reset_mid_sweep();
        bit hit = 1'b0;
        fault_mode = 2;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int n = 0; n < 100 && !hit; n++) begin
            if (bus.busy && {bus.dut_a, bus.dut_b} == 4'd5) hit = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL mid_rst_reach_vec5: got timeout want vec=5");
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.dut_a !== '0 || bus.dut_b !== '0 ||
            bus.err_count !== '0 || bus.first_fail_valid !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL mid_rst_abort: got busy=%0b a=%0d b=%0d err=%0d ffvalid=%0b done=%0b want zeros",
                     bus.busy, bus.dut_a, bus.dut_b, bus.err_count, bus.first_fail_valid, bus.done);
        end
        test_sweep(0, "after_rst", -1);
    endtask

    task automatic test_restart();
        bit fin = 1'b0;
        test_sweep(0, "repulse", 3);
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL restart_from_done: got done=%0b busy=%0b want done=0 busy=1", bus.done, bus.busy);
        end
        for (int n = 0; n < 100 && !fin; n++) begin
            if (bus.done) fin = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!fin || bus.pass !== 1'b1) begin
            failures++;
            $display("FAIL restart_sweep: got done=%0b pass=%0b want 1 1", bus.done, bus.pass);
        end
    endtask

    task automatic test_random_faults();
        for (int r = 0; r < 4; r++) begin
            for (int v = 0; v < NVEC; v++)
                fault_mask[v] = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            test_sweep(4, $sformatf("random%0d", r), -1);
        end
    endtask

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        for (int v = 0; v < NVEC; v++) fault_mask[v] = 3'b000;
        test_reset();
        test_sweep(0, "ideal", -1);
        test_sweep(1, "stuck010", -1);
        test_sweep(2, "stuck000", -1);
        test_sweep(3, "swapped", -1);
        test_reset_mid_sweep();
        test_restart();
        test_random_faults();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
